// File: rtl/sdram_host_adapter.sv
// Purpose: queue host read/write requests and issue them one at a time to the SDRAM controller host port.
// Latency: enable 2 cycles after a push into an idle queue; wr_done on busy fall, rsp_valid READ_LATENCY cycles later.
// Backpressure: req_ready = queue not full; controller backpressure via busy, unacknowledged enables re-issued on timeout.

// Small synchronous FIFO with combinational head output.
module sha_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign push_ok = wr_en && !full;
    assign pop_ok  = rd_en && !empty;
    assign rd_dat  = mem[rd_ptr];

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_dat;
    end
endmodule

module sdram_host_adapter #(
    parameter int HADDR_WIDTH  = 24,
    parameter int FIFO_DEPTH   = 4,
    parameter int INIT_CYCLES  = 64,
    parameter int ACK_TIMEOUT  = 15,
    parameter int READ_LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [HADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [15:0]            rsp_data,
    output logic                   wr_done,
    output logic [7:0]             retry_cnt,
    output logic [HADDR_WIDTH-1:0] ctrl_haddr,
    output logic [15:0]            ctrl_data_in,
    output logic                   ctrl_rd_enable,
    output logic                   ctrl_wr_enable,
    input  logic                   ctrl_busy,
    input  logic [15:0]            ctrl_data_out
);
    localparam int CW = 16;

    typedef struct packed {
        logic                   we;
        logic [HADDR_WIDTH-1:0] addr;
        logic [15:0]            wdata;
    } req_t;

    typedef enum logic [2:0] {
        WAIT_INIT,
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        READ_WAIT
    } state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    req_t        req_in;
    req_t        head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        wr_done_c;
    logic        rsp_valid_c;
    logic        retry_inc;
    logic [15:0] rsp_data_q;

    assign req_in    = '{we: req_we, addr: req_addr, wdata: req_wdata};
    assign req_ready = !fifo_full;

    sha_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (req_valid),
        .wr_dat (req_in),
        .rd_en  (pop),
        .rd_dat (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Next-state, shared down-counter and completion strobes.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        pop         = 1'b0;
        wr_done_c   = 1'b0;
        rsp_valid_c = 1'b0;
        retry_inc   = 1'b0;
        case (state)
            WAIT_INIT: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - CW'(1);
            end
            IDLE: begin
                if (!fifo_empty) state_n = ISSUE;
            end
            ISSUE: begin
                cnt_n   = CW'(ACK_TIMEOUT - 1);
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (ctrl_busy) begin
                    state_n = WAIT_DONE;
                end else if (cnt == '0) begin
                    // Controller was in init/refresh and dropped the enable.
                    retry_inc = 1'b1;
                    state_n   = ISSUE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!ctrl_busy) begin
                    if (head.we) begin
                        pop       = 1'b1;
                        wr_done_c = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        cnt_n   = CW'(READ_LATENCY - 1);
                        state_n = READ_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (cnt == '0) begin
                    rsp_valid_c = 1'b1;
                    pop         = 1'b1;
                    state_n     = IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = WAIT_INIT;
        endcase
    end

    // State, registered enables/command fields, retry counter and read data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= WAIT_INIT;
            cnt            <= CW'(INIT_CYCLES - 1);
            ctrl_rd_enable <= 1'b0;
            ctrl_wr_enable <= 1'b0;
            ctrl_haddr     <= '0;
            ctrl_data_in   <= '0;
            retry_cnt      <= '0;
            rsp_data_q     <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            ctrl_rd_enable <= (state_n == ISSUE) && !head.we;
            ctrl_wr_enable <= (state_n == ISSUE) && head.we;
            // Head stays put until completion, so retries re-load identical fields.
            if (state_n == ISSUE) begin
                ctrl_haddr   <= head.addr;
                ctrl_data_in <= head.wdata;
            end
            if (retry_inc && (retry_cnt != 8'hFF)) retry_cnt <= retry_cnt + 8'd1;
            if (rsp_valid_c) rsp_data_q <= ctrl_data_out;
        end
    end

    // Pulses are presented in the completion cycle itself; read data bypasses the
    // capture register during the pulse and is held from the register afterwards.
    assign wr_done   = wr_done_c && !rst;
    assign rsp_valid = rsp_valid_c && !rst;
    assign rsp_data  = rsp_valid ? ctrl_data_out : rsp_data_q;
endmodule

// File: tb/tb_sdram_host_adapter.sv
// Bench for sdram_host_adapter: directed scenarios plus random traffic against a
// transaction-level reference model and a small behavioural SDRAM controller.
module tb_sdram_host_adapter;
    localparam int HW    = 24;
    localparam int DEPTH = 4;
    localparam int INIT  = 64;
    localparam int ACKT  = 15;
    localparam int RL    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [HW-1:0] req_addr;
    logic [15:0]   req_wdata;
    logic          rsp_valid;
    logic [15:0]   rsp_data;
    logic          wr_done;
    logic [7:0]    retry_cnt;
    logic [HW-1:0] ctrl_haddr;
    logic [15:0]   ctrl_data_in;
    logic          ctrl_rd_enable, ctrl_wr_enable;
    logic          ctrl_busy;
    logic [15:0]   ctrl_data_out;

    sdram_host_adapter #(
        .HADDR_WIDTH (HW), .FIFO_DEPTH (DEPTH), .INIT_CYCLES (INIT),
        .ACK_TIMEOUT (ACKT), .READ_LATENCY (RL)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
        .req_addr (req_addr), .req_wdata (req_wdata),
        .rsp_valid (rsp_valid), .rsp_data (rsp_data), .wr_done (wr_done),
        .retry_cnt (retry_cnt),
        .ctrl_haddr (ctrl_haddr), .ctrl_data_in (ctrl_data_in),
        .ctrl_rd_enable (ctrl_rd_enable), .ctrl_wr_enable (ctrl_wr_enable),
        .ctrl_busy (ctrl_busy), .ctrl_data_out (ctrl_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Unwritten SDRAM locations read back as a fixed function of the address.
    function automatic logic [15:0] fdat(input logic [HW-1:0] a);
        return a[15:0] ^ 16'hB9F9;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Behavioural controller state.
    int          b_start = -10, b_end = -10;
    logic [15:0] c_data = '0;
    int          ign_left = 0;
    bit          rnd_mode = 0;
    logic [15:0] cmem [int];

    // Observed DUT events.
    int          en_cyc[$];
    logic [HW-1:0] en_addr[$];
    logic [15:0] en_data[$];
    bit          en_we[$];
    int          wd_cyc[$];
    logic [HW-1:0] wd_addr[$];
    int          rv_cyc = -1, rv_n = 0;
    logic [15:0] rv_data = '0;

    // Reference model state.
    typedef struct {
        bit          we;
        logic [HW-1:0] addr;
        logic [15:0] wdata;
        int          pc;
    } mreq_t;
    mreq_t       mq[$];
    mreq_t       cur;
    logic [15:0] ref_mem [int];
    bit          outst = 0, acked = 0, fallen = 0, done_f = 0;
    int          e_cyc = 0, ack_cyc = 0, rd_due = 0, last_done = -100, base = 0;
    int          retries = 0;
    logic [HW-1:0] m_haddr = '0;
    logic [15:0] m_din = '0, m_rsp = '0;
    logic        exp_ready, exp_wr, exp_rd, exp_wd, exp_rv;

    // Controller drives busy/data shortly after each rising edge.
    initial begin
        ctrl_busy     = 1'b0;
        ctrl_data_out = '0;
        forever begin
            @(posedge clk);
            #1;
            ctrl_busy     = (cyc >= b_start) && (cyc < b_end);
            ctrl_data_out = c_data;
        end
    end

    // Per-cycle: controller reaction, event capture, model step and comparison.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            mq.delete();
            outst   = 0;
            retries = 0;
            m_haddr = '0;
            m_din   = '0;
            m_rsp   = '0;
            last_done = -100;
            // INIT_CYCLES in the init wait, one cycle in IDLE, then the enable.
            base = cyc + INIT + 2;
        end else begin
            if (ctrl_wr_enable || ctrl_rd_enable) begin
                en_cyc.push_back(cyc);
                en_addr.push_back(ctrl_haddr);
                en_data.push_back(ctrl_data_in);
                en_we.push_back(ctrl_wr_enable);
                if (ign_left > 0) begin
                    ign_left--;
                end else if (!(rnd_mode && $urandom_range(0, 7) == 0)) begin
                    b_start = cyc + (rnd_mode ? int'($urandom_range(2, 4)) : 2);
                    b_end   = b_start + (rnd_mode ? int'($urandom_range(1, 3)) : 1);
                    if (ctrl_wr_enable) cmem[int'(ctrl_haddr)] = ctrl_data_in;
                    else c_data = cmem.exists(int'(ctrl_haddr)) ? cmem[int'(ctrl_haddr)] : fdat(ctrl_haddr);
                end
            end
            if (wr_done) begin
                wd_cyc.push_back(cyc);
                wd_addr.push_back(ctrl_haddr);
            end
            if (rsp_valid) begin
                rv_cyc  = cyc;
                rv_n++;
                rv_data = rsp_data;
            end

            exp_ready = (mq.size() < DEPTH);
            exp_wr = 0; exp_rd = 0; exp_wd = 0; exp_rv = 0; done_f = 0;
            if (!outst && mq.size() > 0 && cyc >= max3(mq[0].pc + 2, last_done + 2, base)) begin
                outst = 1; acked = 0; fallen = 0; e_cyc = cyc; cur = mq[0];
                m_haddr = cur.addr; m_din = cur.wdata;
                exp_wr = cur.we; exp_rd = !cur.we;
            end else if (outst && !acked && cyc == e_cyc + ACKT + 1) begin
                if (retries < 255) retries++;
                e_cyc = cyc;
                exp_wr = cur.we; exp_rd = !cur.we;
            end else if (outst && !acked && ctrl_busy && cyc > e_cyc) begin
                acked = 1; ack_cyc = cyc;
            end else if (outst && acked && !fallen && !ctrl_busy && cyc > ack_cyc) begin
                if (cur.we) begin
                    exp_wd = 1;
                    ref_mem[int'(cur.addr)] = cur.wdata;
                    done_f = 1;
                end else begin
                    fallen = 1;
                    rd_due = cyc + RL;
                end
            end else if (outst && fallen && cyc == rd_due) begin
                exp_rv = 1;
                m_rsp  = ref_mem.exists(int'(cur.addr)) ? ref_mem[int'(cur.addr)] : fdat(cur.addr);
                done_f = 1;
            end
            if (done_f) begin
                void'(mq.pop_front());
                outst = 0;
                last_done = cyc;
            end
            if (req_valid && exp_ready) mq.push_back('{req_we, req_addr, req_wdata, cyc});

            chk("req_ready", req_ready, exp_ready);
            chk("wr_enable", ctrl_wr_enable, exp_wr);
            chk("rd_enable", ctrl_rd_enable, exp_rd);
            chk("wr_done", wr_done, exp_wd);
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("rsp_data", rsp_data, m_rsp);
            chk("retry_cnt", retry_cnt, retries);
            chk("ctrl_haddr", ctrl_haddr, m_haddr);
            chk("ctrl_data_in", ctrl_data_in, m_din);
        end
    end

    task automatic push(input bit we, input logic [HW-1:0] a, input logic [15:0] d, output int acc);
        bit ok;
        ok  = 0;
        acc = -1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; acc = cyc; end
        end
        chk("push_accepted", ok, 1);
    endtask

    task automatic drop();
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_wd(input int n, input int budget);
        for (int i = 0; i < budget && wd_cyc.size() < n; i++) begin @(negedge clk); #1; end
        chk("wait_wr_done", wd_cyc.size() >= n, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rel, acc, n0, r0, e, rv0, acc_last;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rel = cyc;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_retry_cnt", retry_cnt, 0);
        chk("reset_wr_enable", ctrl_wr_enable, 0);
        chk("reset_haddr", ctrl_haddr, 0);

        // Write queued during the init window.
        push(1, 24'h000123, 16'hBEEF, acc);
        drop();
        wait_wd(1, 200);
        chk("init_enable_count", en_cyc.size(), 1);
        chk("init_enable_cycle", en_cyc[0], rel + 65);
        chk("init_enable_addr", en_addr[0], 24'h000123);
        chk("init_enable_data", en_data[0], 16'hBEEF);
        chk("init_wr_done_cycle", wd_cyc[0], en_cyc[0] + 3);

        // Single read with controller data 0x1234.
        push(0, 24'h00ABCD, 16'h0000, acc);
        drop();
        for (int i = 0; i < 100 && rv_n < 1; i++) begin @(negedge clk); #1; end
        e = en_cyc[en_cyc.size()-1];
        chk("read_is_rd_enable", en_we[en_we.size()-1], 0);
        chk("read_rsp_cycle", rv_cyc, e + 3 + RL);
        chk("read_rsp_data", rv_data, 16'h1234);
        repeat (5) @(negedge clk);
        chk("read_rsp_hold", rsp_data, 16'h1234);

        // Five back-to-back writes into a four-deep queue.
        n0 = wd_cyc.size();
        for (int i = 0; i < 4; i++) push(1, 24'h000100 + i, 16'hA000 + 16'(i), acc);
        drop();
        @(negedge clk);
        chk("burst_ready_low", req_ready, 0);
        push(1, 24'h000104, 16'hA004, acc);
        drop();
        chk("burst_5th_accept", acc, wd_cyc[n0] + 1);
        wait_wd(n0 + 5, 200);
        for (int i = 0; i < 5; i++) chk("burst_order", wd_addr[n0+i], 24'h000100 + i);

        // First enable ignored by the controller.
        r0 = en_cyc.size();
        n0 = wd_cyc.size();
        ign_left = 1;
        push(1, 24'h000777, 16'h5555, acc);
        drop();
        wait_wd(n0 + 1, 100);
        repeat (20) @(negedge clk);
        chk("retry_cnt_one", retry_cnt, 1);
        chk("retry_enable_count", en_cyc.size() - r0, 2);
        chk("retry_gap", en_cyc[r0+1] - en_cyc[r0], ACKT + 1);
        chk("retry_addr", en_addr[r0+1], 24'h000777);
        chk("retry_data", en_data[r0+1], 16'h5555);
        chk("retry_single_done", wd_cyc.size(), n0 + 1);

        // Reset while the read latency counter is running.
        r0 = en_cyc.size();
        push(0, 24'h0000AA, 16'h0000, acc);
        drop();
        for (int i = 0; i < 50 && en_cyc.size() <= r0; i++) begin @(negedge clk); #1; end
        e = en_cyc[r0];
        for (int i = 0; i < 50 && cyc < e + 5; i++) begin @(posedge clk); #1; end
        rst = 1'b1;
        rv0 = rv_n;
        @(posedge clk); #1;
        rst = 1'b0;
        rel = cyc;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rd_enable", ctrl_rd_enable, 0);
        chk("rst_retry_cnt", retry_cnt, 0);
        n0 = wd_cyc.size();
        push(1, 24'h000999, 16'h0F0F, acc);
        drop();
        wait_wd(n0 + 1, 200);
        chk("rst_no_rsp", rv_n, rv0);
        chk("rst_reinit_cycle", en_cyc[en_cyc.size()-1], rel + 65);
        chk("rst_reinit_addr", en_addr[en_cyc.size()-1], 24'h000999);

        // Retry counter saturation.
        n0 = wd_cyc.size();
        ign_left = 300;
        push(1, 24'h000555, 16'h3C3C, acc);
        drop();
        wait_wd(n0 + 1, 300 * (ACKT + 1) + 200);
        chk("retry_saturated", retry_cnt, 255);

        // Random traffic with random controller timing and dropped enables.
        rnd_mode = 1;
        acc_last = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!req_valid || acc_last != 0) begin
                req_valid = ($urandom_range(0, 2) != 0);
                req_we    = $urandom_range(0, 1) != 0;
                req_addr  = 24'($urandom_range(0, 15));
                req_wdata = 16'($urandom);
            end
            @(negedge clk);
            acc_last = int'(req_valid && req_ready);
        end
        drop();
        for (int i = 0; i < 3000 && (mq.size() != 0 || outst); i++) begin @(negedge clk); #1; end
        chk("random_drained", mq.size() == 0 && !outst, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
